// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter: FSM state encoding
// and the width of the ACCESS timeout counter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // clog2(timeout + 1), never narrower than one bit so TIMEOUT = 0 still elaborates.
  function automatic int tmo_cnt_width(input int timeout);
    for (int w = 1; w < 32; w++) begin
      if ((64'd1 << w) >= 64'(timeout) + 64'd1) begin
        return w;
      end
    end
    return 32;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the first active request found when
// scanning upward from ptr_i (with wrap-around) wins.
module rr_arbiter #(
  parameter int NB_REQ = 4,
  parameter int IDX_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic [NB_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NB_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic             found_s;
  logic             hit_s;
  logic [IDX_W-1:0] cand_s;

  // Rotating priority scan; the first hit latches and later candidates are ignored.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand_s  = IDX_W'((int'(ptr_i) + i) % NB_REQ);
      hit_s   = req_i[cand_s] & ~found_s;
      idx_o   = hit_s ? cand_s : idx_o;
      found_s = found_s | hit_s;
    end
    if (found_s) begin
      gnt_o[idx_o] = 1'b1;
    end else begin
      gnt_o = '0;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that funnels NB_REQ simple requesters onto one APB
// master port, with an optional ACCESS-phase timeout.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NB_REQ         = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 255
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NB_REQ-1:0]                        req_i,
  input  logic [NB_REQ-1:0]                        we_i,
  input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]    addr_i,
  input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]    wdata_i,
  output logic [NB_REQ-1:0]                        gnt_o,
  output logic [NB_REQ-1:0]                        rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]                rdata_o,
  output logic                                     err_o,
  output logic                                     psel_o,
  output logic                                     penable_o,
  output logic                                     pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]                paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]                prdata_i,
  input  logic                                     pready_i,
  input  logic                                     pslverr_i
);

  localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int CNT_W = tmo_cnt_width(TIMEOUT);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          rr_q, rr_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          cnt_inc_s;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [NB_REQ-1:0]         rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [NB_REQ-1:0]         arb_gnt_s;
  logic [IDX_W-1:0]          arb_idx_s;
  logic                      done_s;
  logic                      tmo_s;

  rr_arbiter #(
    .NB_REQ (NB_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .req_i (req_i),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s)
  );

  // Next-state, capture and completion logic.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rvalid_d  = '0;
    rdata_d   = '0;
    err_d     = 1'b0;
    done_s    = 1'b0;
    tmo_s     = 1'b0;
    cnt_inc_s = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d  = SETUP;
          owner_d  = arb_idx_s;
          rr_d     = (arb_idx_s == IDX_W'(NB_REQ - 1)) ? '0 : arb_idx_s + IDX_W'(1);
          pwrite_d = we_i[arb_idx_s];
          paddr_d  = addr_i[arb_idx_s];
          pwdata_d = wdata_i[arb_idx_s];
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (pready_i) begin
          done_s  = 1'b1;
          state_d = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_inc_s == CNT_W'(TIMEOUT))) begin
          tmo_s   = 1'b1;
          state_d = IDLE;
          cnt_d   = cnt_inc_s;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A timed-out transfer reports an error with no data, whatever the slave drives.
    if (done_s || tmo_s) begin
      rvalid_d = NB_REQ'(1'b1) << owner_q;
      rdata_d  = (done_s && !pwrite_q) ? prdata_i : '0;
      err_d    = tmo_s ? 1'b1 : pslverr_i;
    end else begin
      rvalid_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign gnt_o     = (state_q == IDLE) ? arb_gnt_s : '0;
  assign psel_o    = (state_q != IDLE);
  assign penable_o = (state_q == ACCESS);
  assign pwrite_o  = psel_o ? pwrite_q : 1'b0;
  assign paddr_o   = psel_o ? paddr_q : '0;
  assign pwdata_o  = psel_o ? pwdata_q : '0;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized and directed bench for apb_master_arbiter against a
// transaction-level round-robin/APB model.
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]         req, we, gnt, rvalid;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] wdata;
  logic [DW-1:0]        rdata, prdata, pwdata;
  logic [AW-1:0]        paddr;
  logic                 err, psel, penable, pwrite, pready, pslverr;

  logic [N-1:0]         t_req, t_we, t_gnt, t_rvalid;
  logic [N-1:0][AW-1:0] t_addr;
  logic [N-1:0][DW-1:0] t_wdata;
  logic [DW-1:0]        t_rdata, t_prdata, t_pwdata;
  logic [AW-1:0]        t_paddr;
  logic                 t_err, t_psel, t_penable, t_pwrite, t_pready, t_pslverr;

  apb_master_arbiter #(.NB_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  apb_master_arbiter #(.NB_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT(4)) dut_tmo (
    .clk_i(clk), .rst_i(rst), .req_i(t_req), .we_i(t_we), .addr_i(t_addr), .wdata_i(t_wdata),
    .gnt_o(t_gnt), .rvalid_o(t_rvalid), .rdata_o(t_rdata), .err_o(t_err),
    .psel_o(t_psel), .penable_o(t_penable), .pwrite_o(t_pwrite), .paddr_o(t_paddr), .pwdata_o(t_pwdata),
    .prdata_i(t_prdata), .pready_i(t_pready), .pslverr_i(t_pslverr)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: pending requests, their payloads and the rotation pointer.
  bit            pend [N];
  bit            m_we [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_wdata [N];
  int            ptr = 0;
  logic [N-1:0]  exp_rv = '0;
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i] = 1'b1; m_we[i] = w; m_addr[i] = a; m_wdata[i] = d;
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    req = '0;
  endtask

  task automatic check_done();
    check("rvalid", rvalid, exp_rv);
    check("rdata", rdata, exp_rdata);
    check("err", err, exp_err);
  endtask

  task automatic clear_exp();
    exp_rv = '0; exp_rdata = '0; exp_err = 1'b0;
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next one.
  task automatic idle_cycle();
    @(negedge clk);
    check_done();
    check("idle_gnt", gnt, '0);
    check("idle_psel", psel, 1'b0);
    check("idle_paddr", paddr, '0);
    @(posedge clk); #1;
    clear_exp();
  endtask

  task automatic xfer(input int waits, input logic [DW-1:0] rd, input bit serr, input bit hold,
                      output int w, output int gcyc);
    bit            ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    w  = pick();
    ew = m_we[w]; ea = m_addr[w]; ed = m_wdata[w];
    @(negedge clk);
    check_done();
    check("gnt", gnt, N'(1) << w);
    check("grant_psel", psel, 1'b0);
    gcyc = cycle;
    @(posedge clk); #1;
    clear_exp();
    ptr = (w + 1) % N;
    // Payload changes after the grant must not reach the bus.
    if (hold) begin
      m_we[w] = 1'($urandom_range(0, 1)); m_addr[w] = $urandom; m_wdata[w] = $urandom;
      we[w] = m_we[w]; addr[w] = m_addr[w]; wdata[w] = m_wdata[w];
    end else begin
      pend[w] = 1'b0; req[w] = 1'b0;
      we[w] = 1'($urandom_range(0, 1)); addr[w] = $urandom; wdata[w] = $urandom;
    end
    pready = 1'b0;
    @(negedge clk);
    check("setup_psel", psel, 1'b1);
    check("setup_penable", penable, 1'b0);
    check("setup_paddr", paddr, ea);
    check("setup_pwdata", pwdata, ed);
    check("setup_pwrite", pwrite, ew);
    check("setup_gnt", gnt, '0);
    for (int k = 0; k <= waits; k++) begin
      @(posedge clk); #1;
      pready  = (k == waits);
      prdata  = (k == waits) ? rd : $urandom;
      pslverr = (k == waits) ? serr : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("acc_psel", psel, 1'b1);
      check("acc_penable", penable, 1'b1);
      check("acc_paddr", paddr, ea);
      check("acc_pwdata", pwdata, ed);
      check("acc_pwrite", pwrite, ew);
      check("acc_gnt", gnt, '0);
      check("acc_rvalid", rvalid, '0);
    end
    @(posedge clk); #1;
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    exp_rv    = N'(1) << w;
    exp_rdata = ew ? '0 : rd;
    exp_err   = serr;
  endtask

  initial begin
    int w, g, gprev;
    req = '0; we = '0; addr = '0; wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    t_req = '0; t_we = '0; t_addr = '0; t_wdata = '0;
    t_prdata = '0; t_pready = 1'b0; t_pslverr = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_rvalid", rvalid, '0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;

    // Round-robin with all four requesters held and a zero-wait slave.
    for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    gprev = 0;
    for (int k = 0; k < 5; k++) begin
      xfer(0, $urandom, 1'b0, 1'b1, w, g);
      if (k > 0) check("rr_spacing", g - gprev, 3);
      gprev = g;
    end
    clear_reqs();
    idle_cycle();

    // Single read.
    set_req(0, 1'b0, 32'h1A10_0004, 32'h0);
    xfer(0, 32'hDEAD_BEEF, 1'b0, 1'b0, w, g);
    idle_cycle();

    // Five wait states on a write.
    set_req(2, 1'b1, 32'h4000_0020, 32'hCAFE_F00D);
    xfer(5, $urandom, 1'b0, 1'b0, w, g);
    idle_cycle();

    // Slave error on a write.
    set_req(1, 1'b1, 32'h5000_0000, 32'h0BAD_0BAD);
    xfer(0, 32'h1234_5678, 1'b1, 1'b0, w, g);
    idle_cycle();

    // Random traffic.
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      if (pick() >= 0) xfer(int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0), 1'b0, w, g);
      else idle_cycle();
    end
    clear_reqs();
    idle_cycle();

    // Reset in the middle of a waited ACCESS phase.
    set_req(2, 1'b0, 32'h6000_0004, 32'h0);
    @(negedge clk);
    check_done();
    check("mid_gnt", gnt, 4'b0100);
    @(posedge clk); #1;
    clear_exp(); pend[2] = 1'b0; req[2] = 1'b0; pready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_penable", penable, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_psel", psel, 1'b0);
    check("mid_rst_penable", penable, 1'b0);
    check("mid_rst_rvalid", rvalid, '0);
    #1 rst = 1'b0;
    ptr = 0;
    @(posedge clk); #1;
    idle_cycle();
    set_req(3, 1'b0, 32'h7000_0000, 32'h0);
    set_req(0, 1'b1, 32'h7000_0010, 32'h5555_AAAA);
    xfer(1, $urandom, 1'b0, 1'b0, w, g);
    xfer(0, $urandom, 1'b0, 1'b0, w, g);
    idle_cycle();

    // Timeout instance: slave never answers.
    t_req = 4'b0001; t_we = 4'b0000; t_addr[0] = 32'h2000_0010; t_prdata = 32'h1234_5678;
    @(negedge clk);
    check("tmo_gnt", t_gnt, 4'b0001);
    @(posedge clk); #1;
    t_req = '0;
    @(negedge clk);
    check("tmo_setup_psel", t_psel, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("tmo_acc_penable", t_penable, 1'b1);
      check("tmo_acc_rvalid", t_rvalid, '0);
    end
    @(negedge clk);
    check("tmo_end_psel", t_psel, 1'b0);
    check("tmo_rvalid", t_rvalid, 4'b0001);
    check("tmo_err", t_err, 1'b1);
    check("tmo_rdata", t_rdata, '0);
    @(negedge clk);
    check("tmo_rvalid_clr", t_rvalid, '0);
    check("tmo_err_clr", t_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
